// File: rtl/fft_sequencer.sv
// Stage/butterfly sequencer for an in-place radix-2 DIT FFT: walks every stage,
// issues one butterfly read per cycle and replays the addresses one cycle later as writes.
module fft_sequencer #(
  parameter  int N_LOG2 = 5,
  localparam int SW     = $clog2(N_LOG2),
  localparam int JW     = N_LOG2 - 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [SW-1:0]     stage,
  output logic              rd_en,
  output logic [N_LOG2-1:0] rd_addr_a,
  output logic [N_LOG2-1:0] rd_addr_b,
  output logic [JW-1:0]     tw_addr,
  output logic              wr_en,
  output logic [N_LOG2-1:0] wr_addr_a,
  output logic [N_LOG2-1:0] wr_addr_b,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2, DONE = 2'd3} state_t;

  localparam logic [JW-1:0] J_LAST = '1;
  localparam logic [SW-1:0] S_LAST = SW'(N_LOG2 - 1);

  state_t          state, state_n;
  logic [SW-1:0]   s, s_n;
  logic [JW-1:0]   j, j_n;

  // Registered-output intermediates, computed from the current state.
  logic              rd_en_d, busy_d, done_d;
  logic [N_LOG2-1:0] half, jx, k, g, a_d, b_d;
  logic [JW-1:0]     tw_d;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      s     <= '0;
      j     <= '0;
    end else begin
      state <= state_n;
      s     <= s_n;
      j     <= j_n;
    end
  end

  // Next-state logic; start is only looked at in IDLE, never queued.
  always_comb begin
    state_n = state;
    s_n     = s;
    j_n     = j;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_n = RUN;
          s_n     = '0;
          j_n     = '0;
        end
      end
      RUN: begin
        if (j == J_LAST) state_n = DRAIN;
        else             j_n     = j + JW'(1);
      end
      DRAIN: begin
        if (s < S_LAST) begin
          state_n = RUN;
          s_n     = s + SW'(1);
          j_n     = '0;
        end else begin
          state_n = DONE;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Output logic: a = 2*half*g + k, b = a + half, tw = k << (N_LOG2-1-s).
  always_comb begin
    jx      = N_LOG2'(j);
    half    = N_LOG2'(1) << s;
    k       = jx & (half - N_LOG2'(1));
    g       = jx >> s;
    a_d     = ((g << s) << 1) | k;
    b_d     = a_d | half;
    tw_d    = JW'(k << (S_LAST - s));
    rd_en_d = (state == RUN);
    busy_d  = (state == RUN) || (state == DRAIN);
    done_d  = (state == DONE);
  end

  // Output registers; the write port replays the read port one cycle later,
  // matching the registered RAM/ROM read feeding the combinational butterfly.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      stage     <= '0;
      rd_en     <= 1'b0;
      rd_addr_a <= '0;
      rd_addr_b <= '0;
      tw_addr   <= '0;
      wr_en     <= 1'b0;
      wr_addr_a <= '0;
      wr_addr_b <= '0;
      dbg_state <= IDLE;
    end else begin
      busy      <= busy_d;
      done      <= done_d;
      stage     <= s;
      rd_en     <= rd_en_d;
      rd_addr_a <= rd_en_d ? a_d : '0;
      rd_addr_b <= rd_en_d ? b_d : '0;
      tw_addr   <= rd_en_d ? tw_d : '0;
      wr_en     <= rd_en;
      wr_addr_a <= rd_addr_a;
      wr_addr_b <= rd_addr_b;
      dbg_state <= state_n;
    end
  end

endmodule

// File: tb/tb_fft_sequencer.sv
// Directed bench for fft_sequencer: reset, address table, pipeline/bubble timing,
// start filtering, mid-run reset and an impulse FFT through a behavioural RAM/butterfly.
module tb_fft_sequencer;

  localparam int N_LOG2 = 5;
  localparam int N      = 32;
  localparam int P      = 17;   // stage period N/2+1
  localparam int LAST   = 85;   // last busy cycle
  localparam int DONE_C = 86;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b1;
  logic       busy, done, rd_en, wr_en;
  logic [2:0] stage;
  logic [4:0] rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b;
  logic [3:0] tw_addr;
  logic [1:0] dbg_state;

  fft_sequencer #(.N_LOG2(N_LOG2)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done), .stage(stage),
    .rd_en(rd_en), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .tw_addr(tw_addr),
    .wr_en(wr_en), .wr_addr_a(wr_addr_a), .wr_addr_b(wr_addr_b), .dbg_state(dbg_state)
  );

  // Clock / watchdog
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  // Scoreboard counters
  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d actual=%0d expected=%0d", nm, cyc, act, exp);
    end
  endtask

  task automatic chk_rng(input string nm, input int act, input int lo, input int hi);
    total++;
    if (act < lo || act > hi) begin
      bad++;
      $display("FAIL %s cycle=%0d actual=%0d expected=%0d..%0d", nm, cyc, act, lo, hi);
    end
  endtask

  // Reference model of one transform, indexed by cycle relative to the start edge
  typedef struct {
    bit rd; int a; int b; int tw; int stg; bit busy; bit done;
  } exp_t;

  function automatic exp_t expect_at(input int rel);
    exp_t e;
    int s, p, half, kk, gg;
    e = '{default: 0};
    if (rel >= 1 && rel <= LAST) begin
      s      = (rel - 1) / P;
      p      = (rel - 1) % P;
      e.busy = 1'b1;
      e.stg  = s;
      if (p < N / 2) begin
        half = 1 << s;
        kk   = p % half;
        gg   = p / half;
        e.rd = 1'b1;
        e.a  = 2 * half * gg + kk;
        e.b  = e.a + half;
        e.tw = kk << (N_LOG2 - 1 - s);
      end
    end
    if (rel == DONE_C) e.done = 1'b1;
    return e;
  endfunction

  // Behavioural dual-port RAM, twiddle ROM and butterfly
  int mre[N], mim[N], twr[N/2], twi[N/2];
  int lar, lai, lbr, lbi, lwr, lwi;

  task automatic ram_step();
    int tr, ti;
    if (wr_en) begin
      tr = (lbr * lwr - lbi * lwi) >>> 15;
      ti = (lbr * lwi + lbi * lwr) >>> 15;
      mre[wr_addr_a] = lar + tr;  mim[wr_addr_a] = lai + ti;
      mre[wr_addr_b] = lar - tr;  mim[wr_addr_b] = lai - ti;
    end
    if (rd_en) begin
      lar = mre[rd_addr_a];  lai = mim[rd_addr_a];
      lbr = mre[rd_addr_b];  lbi = mim[rd_addr_b];
      lwr = twr[tw_addr];    lwi = twi[tw_addr];
    end
  endtask

  function automatic int all_outs();
    return int'({busy, done, rd_en, wr_en, stage, rd_addr_a, rd_addr_b, tw_addr,
                 wr_addr_a, wr_addr_b});
  endfunction

  // Per-cycle check against the model plus the rd->wr pipeline relation
  bit   p_rd;
  int   p_a, p_b;
  exp_t pe;

  task automatic check_cycle(input int rel, input string tag);
    exp_t e;
    e = expect_at(rel);
    chk({tag, "_rd_en"}, rd_en, e.rd);
    chk({tag, "_busy"},  busy,  e.busy);
    chk({tag, "_done"},  done,  e.done);
    chk({tag, "_wr_en"}, wr_en, pe.rd);
    if (e.rd) begin
      chk({tag, "_rd_a"}, rd_addr_a, e.a);
      chk({tag, "_rd_b"}, rd_addr_b, e.b);
      chk({tag, "_tw"},   tw_addr,   e.tw);
    end
    if (pe.rd) begin
      chk({tag, "_wr_a"}, wr_addr_a, pe.a);
      chk({tag, "_wr_b"}, wr_addr_b, pe.b);
    end
    if (e.busy) chk({tag, "_stage"}, stage, e.stg);
    chk({tag, "_pipe_en"}, wr_en, p_rd);
    chk({tag, "_pipe_a"},  wr_addr_a, p_a);
    chk({tag, "_pipe_b"},  wr_addr_b, p_b);
    p_rd = rd_en; p_a = rd_addr_a; p_b = rd_addr_b;
    pe   = e;
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
  endtask

  // Address table applied to the captured first-transform trace
  typedef struct { int s; int j; int a; int b; int tw; } vec_t;
  vec_t vt[7];
  int   cap_a[200], cap_b[200], cap_tw[200], cap_rd[200];

  int rd_cnt, wr_cnt, busy_cnt, done_cnt, rel, c;

  initial begin
    vt[0] = '{0, 0,  0,  1,  0};
    vt[1] = '{1, 1,  1,  3,  8};
    vt[2] = '{2, 6, 10, 14,  8};
    vt[3] = '{4, 5,  5, 21,  5};
    vt[4] = '{0, 15, 30, 31, 0};
    vt[5] = '{3, 15, 23, 31, 14};
    vt[6] = '{4, 15, 15, 31, 15};
    for (int m = 0; m < N / 2; m++) begin
      twr[m] = $rtoi($floor( 32767.0 * $cos(2.0 * 3.14159265358979 * m / N) + 0.5));
      twi[m] = $rtoi($floor(-32767.0 * $sin(2.0 * 3.14159265358979 * m / N) + 0.5));
    end

    // Reset held 3 cycles with start high
    for (int i = 0; i < 3; i++) begin
      step();
      chk("reset_outs", all_outs(), 0);
      chk("reset_state", dbg_state, 0);
    end
    reset = 1'b0;
    start = 1'b0;
    step();
    chk("idle_outs", all_outs(), 0);

    // Transform 1 with ignored starts at cycles 10 and 86, restart at 87
    for (int i = 0; i < N; i++) begin mre[i] = 0; mim[i] = 0; end
    mre[0] = 100;
    p_rd = 0; p_a = 0; p_b = 0; pe = '{default: 0};
    rd_cnt = 0; wr_cnt = 0; done_cnt = 0;
    start = 1'b1;
    step();
    cyc = 0;
    start = 1'b0;
    for (c = 1; c <= 180; c++) begin
      step();
      rel = (c <= 87) ? c : c - 87;
      if (c == 87) rel = 0;
      check_cycle(rel, "trace");
      if (c <= 87) ram_step();
      if (c <= LAST) begin
        cap_rd[c] = rd_en; cap_a[c] = rd_addr_a; cap_b[c] = rd_addr_b; cap_tw[c] = tw_addr;
      end
      if (c <= 87) begin
        rd_cnt += rd_en;
        wr_cnt += wr_en;
      end
      done_cnt += done;
      if (c == 172) chk("done_count_before_restart", done_cnt, 1);
      if (c == 87) begin
        for (int kx = 0; kx < N; kx++) begin
          chk_rng("bin_re", mre[kx], 95, 105);
          chk_rng("bin_im", mim[kx], -5, 5);
        end
      end
      if (c == P || c == 2 * P || c == 3 * P || c == 4 * P || c == 5 * P) begin
        chk("bubble_rd_en", rd_en, 0);
        chk("bubble_wr_en", wr_en, 1);
      end
      start = (c == 9 || c == 85 || c == 86) ? 1'b1 : 1'b0;
    end
    chk("read_cycles", rd_cnt, 80);
    chk("write_cycles", wr_cnt, 80);
    chk("done_count_total", done_cnt, 2);

    for (int i = 0; i < 7; i++) begin
      c = 1 + P * vt[i].s + vt[i].j;
      cyc = c;
      chk("vec_rd_en", cap_rd[c], 1);
      chk("vec_a",     cap_a[c],  vt[i].a);
      chk("vec_b",     cap_b[c],  vt[i].b);
      chk("vec_tw",    cap_tw[c], vt[i].tw);
    end

    // Mid-run reset sampled at cycle 40
    repeat (4) step();
    start = 1'b1;
    step();
    cyc = 0;
    start = 1'b0;
    repeat (39) step();
    reset = 1'b1;
    step();
    chk("midreset_outs", all_outs(), 0);
    chk("midreset_state", dbg_state, 0);
    reset = 1'b0;
    step();
    chk("post_reset_wr_en", wr_en, 0);
    chk("post_reset_rd_en", rd_en, 0);
    chk("post_reset_busy",  busy,  0);
    step();
    chk("post_reset_idle", all_outs(), 0);

    // Clean full transform after the abort
    p_rd = 0; p_a = 0; p_b = 0; pe = '{default: 0};
    rd_cnt = 0; wr_cnt = 0; busy_cnt = 0; done_cnt = 0;
    start = 1'b1;
    step();
    cyc = 0;
    start = 1'b0;
    for (c = 1; c <= 90; c++) begin
      step();
      check_cycle(c, "rerun");
      rd_cnt   += rd_en;
      wr_cnt   += wr_en;
      busy_cnt += busy;
      done_cnt += done;
    end
    chk("rerun_reads",  rd_cnt,   80);
    chk("rerun_writes", wr_cnt,   80);
    chk("rerun_busy",   busy_cnt, 85);
    chk("rerun_done",   done_cnt, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fft_sequencer.md
# fft_sequencer

Control sequencer for the 32-point in-place radix-2 decimation-in-time FFT built around the single combinational `butterflyunit`. It walks all stages and butterflies and generates read/write addresses for a dual-port sample RAM. It also generates the twiddle-ROM index, and start/busy/done status for the capture and display logic. The datapath carries packed {real, imag} 16-bit two's-complement samples and Q1.15 twiddles. This block touches control only; it never sees sample data.

## Interface
- `N_LOG2`, 5, log2 of FFT length; N = 2^N_LOG2 points, N/2 butterflies per stage, N_LOG2 stages
- `clk`  in  1  single clock, all logic on rising edge
- `reset`  in  1  synchronous, active-high
- `start`  in  1  begin a transform; sampled only in IDLE
- `busy`  out  1  high while stages are being executed
- `done`  out  1  one-cycle pulse after the final write
- `stage`  out  $clog2(N_LOG2)  current stage index (debug/status)
- `rd_en`  out  1  read strobe to sample RAM and twiddle ROM
- `rd_addr_a`, `rd_addr_b`  out  N_LOG2  butterfly input addresses (A, B)
- `tw_addr`  out  N_LOG2-1  twiddle ROM index
- `wr_en`  out  1  write strobe for both RAM ports
- `wr_addr_a`, `wr_addr_b`  out  N_LOG2  writeback addresses for butterfly outputs A_f, B_f

## Operation
- States: IDLE, RUN, DRAIN, DONE.
  - IDLE -> RUN on `start`=1, with s=0, j=0.
  - RUN: issue one butterfly per cycle. After j=N/2-1, go to DRAIN.
  - DRAIN: one bubble cycle.
    - If s<N_LOG2-1: s++, j=0, go to RUN.
    - Otherwise go to DONE.
  - DONE: one cycle, then IDLE.
- Address generation, with half = 2^s, k = j mod half, g = j div half:
  - `rd_addr_a` = 2·half·g + k
  - `rd_addr_b` = `rd_addr_a` + half
  - `tw_addr` = k << (N_LOG2-1-s)
- Input is expected in bit-reversed order in RAM; output lands in natural order.
- `rd_en`=1 only in RUN.
- `wr_en`, `wr_addr_a` and `wr_addr_b` are `rd_en`, `rd_addr_a` and `rd_addr_b` delayed by exactly one register stage. This matches the 1-cycle registered RAM/ROM read plus the combinational butterfly.
- The DRAIN bubble ensures a stage's last write commits before the next stage's first read. No read-during-write to the same address ever occurs.
- All outputs are registered.
- Reset values:
  - Every output is 0, and the state is IDLE.
  - Any pending writeback is discarded (`wr_en`=0 on the cycle after reset).
- `start` is ignored in RUN, DRAIN and DONE; it is not queued. Holding `start` high in IDLE after DONE launches a new transform.
- `reset` mid-transform aborts immediately, with no further writes. RAM contents are then undefined, and the transform must be restarted.

## Timing
- Cycle 0 = the `start` edge in IDLE. Stage period P = N/2+1 = 17 cycles for default N_LOG2.
- Stage s reads in cycles 1+P·s … N/2+P·s; its DRAIN cycle is (s+1)·P.
- Stage s writes in cycles 2+P·s … (s+1)·P.
- `busy`=1 in cycles 1 … N_LOG2·P (1…85).
- `done`=1 in cycle N_LOG2·P+1 (86) only. `busy`=0 in that cycle.
- Earliest accepted restart is in IDLE, cycle 87.
- `stage` changes on the first read cycle of each stage and holds through its DRAIN cycle.
- Total latency: start to done = N_LOG2·(N/2+1)+1 = 86 cycles.

## Test plan
- **Reset:** assert `reset` 3 cycles with `start`=1 -> all outputs 0; state stays IDLE while reset is high.
- **Address trace:** `start` pulse, log every `rd_en` cycle. Check against the formula, including:
  - stage 0 j=0 -> a=0, b=1, tw=0
  - stage 1 j=1 -> a=1, b=3, tw=8
  - stage 2 j=6 -> a=10, b=14, tw=8
  - stage 4 j=5 -> a=5, b=21, tw=5
  - exactly 80 read cycles and 80 write cycles in total
- **Pipeline/bubble:** check the following:
  - `wr_*` equals the previous cycle's `rd_*` on every cycle.
  - `rd_en`=0 and `wr_en`=1 in cycles 17, 34, 51, 68, 85.
  - `done`=1 only in cycle 86.
- **Start handling:** pulse `start` in cycles 10 and 86 -> both ignored, `done` count stays 1. `start` in cycle 87 -> new transform, `done` in cycle 173.
- **Mid-run reset:** `reset` in cycle 40 for 1 cycle -> cycle 41 has `wr_en`=0, `rd_en`=0, `busy`=0. A subsequent `start` runs a full clean 86-cycle sequence.
- **Integration:** bench with RAM model and `butterflyunit`, input impulse x[0]=100 (all others 0) -> every bin real = 100 ±5 LSB, imag = 0 ±5 LSB after `done`.
